// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant/select bundle between the round-robin arbiter, its eight
// requesters and the 8-to-1 datapath mux select inputs.
interface mux8_rr_arbiter_if #(
    parameter int HOLD_W = 4
) ();
    logic [7:0]        req;
    logic              s2;
    logic              s1;
    logic              s0;
    logic [7:0]        grant;
    logic              busy;
    logic [HOLD_W-1:0] hold_cnt;

    // Arbiter side
    modport master (
        input  req,
        output s2, s1, s0, grant, busy, hold_cnt
    );

    // Requester / mux side
    modport slave (
        output req,
        input  s2, s1, s0, grant, busy, hold_cnt
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for the shared 8-to-1 mux: grants one requester at a
// time, bounds each grant to MAX_HOLD cycles and forces an idle cycle between owners.
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    mux8_rr_arbiter_if.master        arb_if
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    state_t            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [7:0]        grant_q, grant_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]        last_q, last_d;

    logic [2:0]        winner;
    logic [2:0]        probe;
    logic              found;
    logic              release_now;

    // Rotating priority search starting just after the last released owner.
    always_comb begin
        winner = last_q + 3'd1;
        probe  = last_q;
        found  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            probe = last_q + 3'd1 + 3'(k);
            if (!found && arb_if.req[probe]) begin
                winner = probe;
                found  = 1'b1;
            end
        end
    end

    assign release_now = !arb_if.req[sel_q] || (hold_q == HOLD_MAX);

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = winner;
                    grant_d = 8'b1 << winner;
                    hold_d  = HOLD_ONE;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (release_now) begin
                    grant_d = '0;
                    hold_d  = '0;
                    last_d  = sel_q;
                    state_d = IDLE;
                end else begin
                    hold_d  = hold_q + HOLD_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            grant_q <= '0;
            hold_q  <= '0;
            last_q  <= 3'd7;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign arb_if.s2       = sel_q[2];
    assign arb_if.s1       = sel_q[1];
    assign arb_if.s0       = sel_q[0];
    assign arb_if.grant    = grant_q;
    assign arb_if.busy     = |grant_q;
    assign arb_if.hold_cnt = hold_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: one instance with MAX_HOLD = 8 and one
// with MAX_HOLD = 2 for the rotation sequence.
module tb_mux8_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mux8_rr_arbiter_if #(.HOLD_W(4)) if_a ();
    mux8_rr_arbiter_if #(.HOLD_W(4)) if_b ();

    mux8_rr_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .arb_if (if_a.master)
    );

    mux8_rr_arbiter #(.MAX_HOLD(2), .HOLD_W(4)) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .arb_if (if_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Packed observation: {sel[2:0], grant[7:0], busy, hold[3:0]}
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed sel=%0d grant=%h busy=%b hold=%0d, expected sel=%0d grant=%h busy=%b hold=%0d",
                   tag, obs[15:13], obs[12:5], obs[4], obs[3:0],
                   exp[15:13], exp[12:5], exp[4], exp[3:0]);
        end
    endtask

    task automatic chk_a(input string tag, input logic [2:0] s, input logic [7:0] g,
                         input logic b, input logic [3:0] h);
        check(tag, {if_a.s2, if_a.s1, if_a.s0, if_a.grant, if_a.busy, if_a.hold_cnt},
              {s, g, b, h});
    endtask

    task automatic chk_b(input string tag, input logic [2:0] s, input logic [7:0] g,
                         input logic b, input logic [3:0] h);
        check(tag, {if_b.s2, if_b.s1, if_b.s0, if_b.grant, if_b.busy, if_b.hold_cnt},
              {s, g, b, h});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        if_a.req = 8'h00;
        if_b.req = 8'h00;

        // Reset values appear with no clock edge
        #3;
        chk_a("reset_a", 3'd0, 8'h00, 1'b0, 4'd0);
        chk_b("reset_b", 3'd0, 8'h00, 1'b0, 4'd0);
        cyc();
        rst_n = 1'b1;

        // Single requester 3 for three cycles
        if_a.req = 8'b0000_1000;
        cyc(); chk_a("single_h1", 3'd3, 8'h08, 1'b1, 4'd1);
        cyc(); chk_a("single_h2", 3'd3, 8'h08, 1'b1, 4'd2);
        cyc(); chk_a("single_h3", 3'd3, 8'h08, 1'b1, 4'd3);
        if_a.req = 8'h00;
        cyc(); chk_a("single_release", 3'd3, 8'h00, 1'b0, 4'd0);
        cyc(); chk_a("idle_hold", 3'd3, 8'h00, 1'b0, 4'd0);

        // Make Last = 6, then wrap-around search
        if_a.req = 8'h40;
        cyc(); chk_a("own6", 3'd6, 8'h40, 1'b1, 4'd1);
        if_a.req = 8'h00;
        cyc(); chk_a("own6_release", 3'd6, 8'h00, 1'b0, 4'd0);
        if_a.req = 8'b0100_0001;
        cyc(); chk_a("wrap_last6", 3'd0, 8'h01, 1'b1, 4'd1);
        if_a.req = 8'h00;
        cyc(); chk_a("wrap_release0", 3'd0, 8'h00, 1'b0, 4'd0);
        if_a.req = 8'b0100_0001;
        cyc(); chk_a("wrap_last0", 3'd6, 8'h40, 1'b1, 4'd1);
        if_a.req = 8'h00;
        cyc(); chk_a("wrap_release6", 3'd6, 8'h00, 1'b0, 4'd0);

        // Timeout fairness: Last = 6, requester 2 holds forever, 6 joins
        if_a.req = 8'h04;
        cyc(); chk_a("tmo_h1", 3'd2, 8'h04, 1'b1, 4'd1);
        if_a.req = 8'h44;
        for (int h = 2; h <= 8; h++) begin
            cyc(); chk_a($sformatf("tmo_h%0d", h), 3'd2, 8'h04, 1'b1, 4'(h));
        end
        cyc(); chk_a("tmo_release", 3'd2, 8'h00, 1'b0, 4'd0);
        cyc(); chk_a("tmo_next6", 3'd6, 8'h40, 1'b1, 4'd1);
        if_a.req = 8'h04;
        cyc(); chk_a("tmo_release6", 3'd6, 8'h00, 1'b0, 4'd0);
        cyc(); chk_a("tmo_back2", 3'd2, 8'h04, 1'b1, 4'd1);
        if_a.req = 8'h00;
        cyc(); chk_a("tmo_release2", 3'd2, 8'h00, 1'b0, 4'd0);

        // Transient non-owner request during grant to 1 (Last = 2)
        if_a.req = 8'h02;
        cyc(); chk_a("trans_own1", 3'd1, 8'h02, 1'b1, 4'd1);
        if_a.req = 8'h12;
        cyc(); chk_a("trans_pulse4", 3'd1, 8'h02, 1'b1, 4'd2);
        if_a.req = 8'h02;
        cyc(); chk_a("trans_h3", 3'd1, 8'h02, 1'b1, 4'd3);
        if_a.req = 8'h00;
        cyc(); chk_a("trans_release", 3'd1, 8'h00, 1'b0, 4'd0);
        cyc(); chk_a("trans_idle1", 3'd1, 8'h00, 1'b0, 4'd0);
        cyc(); chk_a("trans_idle2", 3'd1, 8'h00, 1'b0, 4'd0);

        // Round-robin rotation on the MAX_HOLD = 2 instance
        if_b.req = 8'hFF;
        for (int i = 0; i <= 8; i++) begin
            logic [2:0] o;
            o = 3'(i % 8);
            cyc(); chk_b($sformatf("rr%0d_h1", i), o, 8'b1 << o, 1'b1, 4'd1);
            cyc(); chk_b($sformatf("rr%0d_h2", i), o, 8'b1 << o, 1'b1, 4'd2);
            cyc(); chk_b($sformatf("rr%0d_dead", i), o, 8'h00, 1'b0, 4'd0);
        end
        if_b.req = 8'h00;
        cyc(); chk_b("rr_quiet", 3'd0, 8'h00, 1'b0, 4'd0);

        // Reset mid-grant: owner 5 at HoldCnt 3 (Last = 1)
        if_a.req = 8'h20;
        cyc(); chk_a("rst_own5_h1", 3'd5, 8'h20, 1'b1, 4'd1);
        cyc();
        cyc(); chk_a("rst_own5_h3", 3'd5, 8'h20, 1'b1, 4'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk_a("rst_async", 3'd0, 8'h00, 1'b0, 4'd0);
        cyc(); chk_a("rst_held", 3'd0, 8'h00, 1'b0, 4'd0);
        rst_n = 1'b1;
        if_a.req = 8'hFF;
        cyc(); chk_a("rst_first_arb", 3'd0, 8'h01, 1'b1, 4'd1);
        if_a.req = 8'h00;
        cyc(); chk_a("rst_final_release", 3'd0, 8'h00, 1'b0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
